// File: rtl/mdu_iter.sv
// Iterative RV32M multiply/divide unit for the EX stage.
// Multiplies finish in 2 cycles; divides use a 32-step restoring loop, and the RISC-V special cases short-circuit.
module mdu_iter #(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            start_i,
    input  logic [2:0]      op_i,
    input  logic [XLEN-1:0] rs1_i,
    input  logic [XLEN-1:0] rs2_i,
    input  logic            flush_i,
    output logic            busy_o,
    output logic            done_o,
    output logic [XLEN-1:0] result_o
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_MUL  = 3'd1;
    localparam logic [2:0] S_DIV  = 3'd2;
    localparam logic [2:0] S_FIX  = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;

    localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

    logic [2:0]      state_q;
    logic [1:0]      op_q;
    logic [XLEN-1:0] a_q;
    logic [XLEN-1:0] b_q;
    logic [4:0]      cnt_q;
    logic            init_q;
    logic [XLEN-1:0] rem_q;
    logic [XLEN-1:0] quo_q;
    logic [XLEN-1:0] dvs_q;
    logic [XLEN-1:0] result_q;

    // Request decode
    logic start_ovf;
    logic start_dbz;

    // Multiply datapath
    logic            mul_a_sgn;
    logic            mul_b_sgn;
    logic [2*XLEN-1:0] mul_a;
    logic [2*XLEN-1:0] mul_b;
    logic [2*XLEN-1:0] mul_p;
    logic [XLEN-1:0] mul_res;

    // Divide datapath
    logic            a_neg;
    logic            b_neg;
    logic [XLEN-1:0] a_mag;
    logic [XLEN-1:0] b_mag;
    logic [XLEN:0]   shifted;
    logic [XLEN:0]   diff;
    logic            ge;
    logic [XLEN-1:0] rem_nx;
    logic [XLEN-1:0] quo_nx;
    logic [XLEN-1:0] quo_fin;
    logic [XLEN-1:0] rem_fin;
    logic [XLEN-1:0] div_res;
    logic [XLEN-1:0] fix_res;

    assign start_dbz = (rs2_i == '0);
    assign start_ovf = ~op_i[0] & (rs1_i == INT_MIN) & (rs2_i == '1);

    // Sign-extending both operands to 2*XLEN gives the exact low 2*XLEN product bits for every signedness mix.
    always_comb begin
        mul_a_sgn = (op_q != 2'b11) & a_q[XLEN-1];
        mul_b_sgn = ~op_q[1] & b_q[XLEN-1];
        mul_a     = {{XLEN{mul_a_sgn}}, a_q};
        mul_b     = {{XLEN{mul_b_sgn}}, b_q};
        mul_p     = mul_a * mul_b;
        mul_res   = (op_q == 2'b00) ? mul_p[XLEN-1:0] : mul_p[2*XLEN-1:XLEN];
    end

    always_comb begin
        a_neg   = ~op_q[0] & a_q[XLEN-1];
        b_neg   = ~op_q[0] & b_q[XLEN-1];
        a_mag   = a_neg ? (~a_q + 1'b1) : a_q;
        b_mag   = b_neg ? (~b_q + 1'b1) : b_q;
        shifted = {rem_q, quo_q[XLEN-1]};
        diff    = shifted - {1'b0, dvs_q};
        ge      = ~diff[XLEN];
        rem_nx  = ge ? diff[XLEN-1:0] : shifted[XLEN-1:0];
        quo_nx  = {quo_q[XLEN-2:0], ge};
        quo_fin = (a_neg ^ b_neg) ? (~quo_nx + 1'b1) : quo_nx;
        rem_fin = a_neg ? (~rem_nx + 1'b1) : rem_nx;
        div_res = op_q[1] ? rem_fin : quo_fin;
    end

    always_comb begin
        if (b_q == '0) begin
            fix_res = op_q[1] ? a_q : '1;
        end else begin
            fix_res = op_q[1] ? '0 : INT_MIN;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= S_IDLE;
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            cnt_q    <= '0;
            init_q   <= 1'b0;
            rem_q    <= '0;
            quo_q    <= '0;
            dvs_q    <= '0;
            result_q <= '0;
        end else if (flush_i) begin
            state_q <= S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start_i) begin
                        op_q   <= op_i[1:0];
                        a_q    <= rs1_i;
                        b_q    <= rs2_i;
                        cnt_q  <= '1;
                        init_q <= 1'b1;
                        if (!op_i[2]) begin
                            state_q <= S_MUL;
                        end else if (start_dbz || start_ovf) begin
                            state_q <= S_FIX;
                        end else begin
                            state_q <= S_DIV;
                        end
                    end
                end
                S_MUL: begin
                    result_q <= mul_res;
                    state_q  <= S_DONE;
                end
                S_DIV: begin
                    // First DIV cycle only loads magnitudes; the 32 iterations follow.
                    if (init_q) begin
                        rem_q  <= '0;
                        quo_q  <= a_mag;
                        dvs_q  <= b_mag;
                        init_q <= 1'b0;
                    end else begin
                        rem_q <= rem_nx;
                        quo_q <= quo_nx;
                        if (cnt_q == 5'd0) begin
                            result_q <= div_res;
                            state_q  <= S_DONE;
                        end else begin
                            cnt_q <= cnt_q - 5'd1;
                        end
                    end
                end
                S_FIX: begin
                    result_q <= fix_res;
                    state_q  <= S_DONE;
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign busy_o   = (state_q != S_IDLE);
    assign done_o   = (state_q == S_DONE);
    assign result_o = result_q;

endmodule

// File: tb/tb_mdu_iter.sv
// Self-checking bench for mdu_iter: vector table through a result scoreboard,
// plus hand-written flush, start-while-busy and asynchronous-reset sequences.
module tb_mdu_iter;

    logic        clk_i;
    logic        rst_ni;
    logic        start_i;
    logic [2:0]  op_i;
    logic [31:0] rs1_i;
    logic [31:0] rs2_i;
    logic        flush_i;
    logic        busy_o;
    logic        done_o;
    logic [31:0] result_o;

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    logic [31:0] exp_q[$];
    string       name_q[$];

    typedef struct {
        string       nm;
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int unsigned lat;
        bit          disturb;
    } vec_t;

    vec_t vecs[$];

    mdu_iter #(.XLEN(32)) dut (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .start_i  (start_i),
        .op_i     (op_i),
        .rs1_i    (rs1_i),
        .rs2_i    (rs2_i),
        .flush_i  (flush_i),
        .busy_o   (busy_o),
        .done_o   (done_o),
        .result_o (result_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    // Scoreboard: every done_o pulse must match the oldest outstanding expectation.
    always @(posedge clk_i) begin : monitor
        logic [31:0] e;
        string       nm;
        #1;
        if (done_o) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_done: done_o=1 result_o=%h, expected no done", result_o);
            end else begin
                e  = exp_q.pop_front();
                nm = name_q.pop_front();
                check({nm, "_result"}, result_o, e);
            end
        end
    end

    // Called one cycle after the posedge #1 point; start is sampled at the next edge (T).
    task automatic run_op(input string nm, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp,
                          input int unsigned lat, input bit disturb);
        int unsigned k;
        start_i = 1'b1;
        op_i    = op;
        rs1_i   = a;
        rs2_i   = b;
        exp_q.push_back(exp);
        name_q.push_back(nm);
        @(posedge clk_i); #1;
        start_i = 1'b0;
        op_i    = 3'($urandom);
        rs1_i   = $urandom;
        rs2_i   = $urandom;
        check({nm, "_busy_rise"}, 32'(busy_o), 32'd1);
        k = 1;
        while (!done_o && k < 80) begin
            if (disturb && k >= 5 && k <= 7) begin
                start_i = 1'b1;
                op_i    = 3'($urandom);
                rs1_i   = $urandom;
                rs2_i   = $urandom;
            end else begin
                start_i = 1'b0;
            end
            @(posedge clk_i); #1;
            k++;
        end
        check({nm, "_latency"}, 32'(k), 32'(lat));
        if (!done_o) begin
            void'(exp_q.pop_back());
            void'(name_q.pop_back());
        end
        if (disturb) begin
            start_i = 1'b1;
            op_i    = 3'b000;
            rs1_i   = 32'd11;
            rs2_i   = 32'd13;
        end
        @(posedge clk_i); #1;
        start_i = 1'b0;
        check({nm, "_busy_fall"}, 32'(busy_o), 32'd0);
        check({nm, "_done_pulse"}, 32'(done_o), 32'd0);
        check({nm, "_held"}, result_o, exp);
    endtask

    initial begin
        int unsigned saw_done;

        vecs.push_back('{"mul_neg",      3'b000, 32'd7,          32'hFFFFFFFD, 32'hFFFFFFEB, 2,  1'b0});
        vecs.push_back('{"mulh_min",     3'b001, 32'h80000000,   32'h80000000, 32'h40000000, 2,  1'b0});
        vecs.push_back('{"mulhu_max",    3'b011, 32'hFFFFFFFF,   32'hFFFFFFFF, 32'hFFFFFFFE, 2,  1'b0});
        vecs.push_back('{"mulhsu_max",   3'b010, 32'hFFFFFFFF,   32'hFFFFFFFF, 32'hFFFFFFFF, 2,  1'b0});
        vecs.push_back('{"mulh_m1m1",    3'b001, 32'hFFFFFFFF,   32'hFFFFFFFF, 32'h00000000, 2,  1'b0});
        vecs.push_back('{"mulhu_carry",  3'b011, 32'h80000000,   32'd2,        32'h00000001, 2,  1'b0});
        vecs.push_back('{"div_neg",      3'b100, 32'hFFFFFFF9,   32'd2,        32'hFFFFFFFD, 34, 1'b0});
        vecs.push_back('{"rem_neg",      3'b110, 32'hFFFFFFF9,   32'd2,        32'hFFFFFFFF, 34, 1'b0});
        vecs.push_back('{"divu_100_7",   3'b101, 32'd100,        32'd7,        32'd14,       34, 1'b0});
        vecs.push_back('{"remu_100_7",   3'b111, 32'd100,        32'd7,        32'd2,        34, 1'b0});
        vecs.push_back('{"div_negdvs",   3'b100, 32'd7,          32'hFFFFFFFE, 32'hFFFFFFFD, 34, 1'b0});
        vecs.push_back('{"rem_negdvs",   3'b110, 32'd7,          32'hFFFFFFFE, 32'd1,        34, 1'b0});
        vecs.push_back('{"div_min_2",    3'b100, 32'h80000000,   32'd2,        32'hC0000000, 34, 1'b0});
        vecs.push_back('{"rem_m8_3",     3'b110, 32'hFFFFFFF8,   32'd3,        32'hFFFFFFFE, 34, 1'b0});
        vecs.push_back('{"divu_big",     3'b101, 32'hFFFFFFFF,   32'h80000000, 32'd1,        34, 1'b0});
        vecs.push_back('{"remu_big",     3'b111, 32'hFFFFFFFF,   32'h80000000, 32'h7FFFFFFF, 34, 1'b0});
        vecs.push_back('{"divu_noovf",   3'b101, 32'h80000000,   32'hFFFFFFFF, 32'd0,        34, 1'b0});
        vecs.push_back('{"divu_dbz",     3'b101, 32'd5,          32'd0,        32'hFFFFFFFF, 2,  1'b0});
        vecs.push_back('{"div_dbz",      3'b100, 32'd5,          32'd0,        32'hFFFFFFFF, 2,  1'b0});
        vecs.push_back('{"rem_dbz",      3'b110, 32'd5,          32'd0,        32'd5,        2,  1'b0});
        vecs.push_back('{"remu_dbz0",    3'b111, 32'd0,          32'd0,        32'd0,        2,  1'b0});
        vecs.push_back('{"div_ovf",      3'b100, 32'h80000000,   32'hFFFFFFFF, 32'h80000000, 2,  1'b0});
        vecs.push_back('{"rem_ovf",      3'b110, 32'h80000000,   32'hFFFFFFFF, 32'd0,        2,  1'b0});
        vecs.push_back('{"divu_dist",    3'b101, 32'd1000,       32'd7,        32'd142,      34, 1'b1});
        vecs.push_back('{"div_dist",     3'b100, 32'hFFFFFC18,   32'd7,        32'hFFFFFF72, 34, 1'b1});
        vecs.push_back('{"mul_small",    3'b000, 32'h12345678,   32'h10,       32'h23456780, 2,  1'b0});

        rst_ni  = 1'b0;
        start_i = 1'b0;
        flush_i = 1'b0;
        op_i    = '0;
        rs1_i   = '0;
        rs2_i   = '0;

        repeat (3) @(posedge clk_i);
        #1;
        check("reset_busy",   32'(busy_o), 32'd0);
        check("reset_done",   32'(done_o), 32'd0);
        check("reset_result", result_o,    32'd0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(posedge clk_i); #1;

        foreach (vecs[i]) begin
            run_op(vecs[i].nm, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].lat, vecs[i].disturb);
        end

        // Start and flush in the same cycle: the request must be dropped.
        start_i = 1'b1; flush_i = 1'b1; op_i = 3'b000; rs1_i = 32'd3; rs2_i = 32'd4;
        @(posedge clk_i); #1;
        start_i = 1'b0; flush_i = 1'b0;
        check("flush_start_busy", 32'(busy_o), 32'd0);

        // Divide aborted by flush at T+10; previous result must survive.
        start_i = 1'b1; op_i = 3'b100; rs1_i = 32'd1000; rs2_i = 32'd3;
        @(posedge clk_i); #1;
        start_i = 1'b0;
        saw_done = 0;
        repeat (9) begin
            @(posedge clk_i); #1;
            if (done_o) saw_done++;
        end
        flush_i = 1'b1;
        @(posedge clk_i); #1;
        flush_i = 1'b0;
        check("flush_busy",    32'(busy_o),  32'd0);
        check("flush_done",    32'(done_o),  32'd0);
        check("flush_no_done", 32'(saw_done), 32'd0);
        check("flush_result",  result_o,     32'h23456780);
        run_op("div_after_flush", 3'b100, 32'd9, 32'd3, 32'd3, 34, 1'b0);

        // Asynchronous reset between edges in the middle of a divide.
        start_i = 1'b1; op_i = 3'b100; rs1_i = 32'd1000; rs2_i = 32'd3;
        @(posedge clk_i); #1;
        start_i = 1'b0;
        repeat (5) @(posedge clk_i);
        #3;
        rst_ni = 1'b0;
        #1;
        check("arst_busy",   32'(busy_o), 32'd0);
        check("arst_done",   32'(done_o), 32'd0);
        check("arst_result", result_o,    32'd0);
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(posedge clk_i); #1;
        check("arst_release_busy", 32'(busy_o), 32'd0);
        run_op("mul_after_reset", 3'b000, 32'd2, 32'd3, 32'd6, 2, 1'b0);

        repeat (3) @(posedge clk_i);
        #2;
        check("sb_drained", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
